ama_riscv_dmem_ctrl: RTL and testbench

Data-memory request controller between the EX/MEM pipeline boundary and the data memory port, directly upstream of the load shift/mask stage. It issues one load or store at a time over a request/grant plus response-valid handshake, aligns store data and byte enables, and detects misaligned or illegal accesses. It also stalls the pipeline while an access is in flight and hands the raw load word with its offset and width to the load shift/mask stage.

---
 rtl/ama_riscv_dmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_ama_riscv_dmem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_dmem_ctrl.sv
// Data-memory request controller: one outstanding load/store over a req/gnt + rvalid
// handshake, store lane alignment, fault detection, pipeline stall and load hand-off.
module ama_riscv_dmem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        lsm_en,
    output logic [1:0]  lsm_offset,
    output logic [2:0]  lsm_width,
    output logic [31:0] lsm_data,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  width_q, width_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic [1:0]  req_off;
    logic        misaligned, illegal, idle_req;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata_al;

    assign req_off = req_addr[1:0];

    always_comb begin
        misaligned   = ((req_width[1:0] == 2'd1) && (req_off == 2'd3)) ||
                       ((req_width[1:0] == 2'd2) && (req_off != 2'd0));
        illegal      = (req_width[1:0] == 2'd3) || (req_we && req_width[2]);
        idle_req     = req_valid && !misaligned && !illegal;
        req_wmask    = 4'b0000;
        case (req_width[1:0])
            2'd0:    req_wmask = 4'b0001 << req_off;
            2'd1:    req_wmask = 4'b0011 << req_off;
            2'd2:    req_wmask = 4'b1111;
            default: req_wmask = 4'b0000;
        endcase
        if (!req_we) req_wmask = 4'b0000;
        req_wdata_al = req_wdata << {req_off, 3'b000};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (idle_req) state_d = mem_gnt ? RESP : REQ;
            REQ:     if (mem_gnt) state_d = RESP;
            RESP:    if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        fault      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_wmask  = wmask_q;
        mem_wdata  = wdata_q;
        lsm_en     = 1'b0;
        case (state_q)
            IDLE: begin
                fault     = req_valid && (misaligned || illegal);
                mem_req   = idle_req;
                mem_we    = req_we;
                mem_addr  = req_addr[31:2];
                mem_wmask = req_wmask;
                mem_wdata = req_wdata_al;
                stall     = idle_req;
            end
            REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
            end
            RESP: begin
                stall  = !mem_rvalid;
                lsm_en = mem_rvalid && !we_q;
            end
            default: ;
        endcase
    end

    assign lsm_offset = off_q;
    assign lsm_width  = width_q;
    assign lsm_data   = mem_rdata;
    assign stall_cnt  = stall_cnt_q;

    // Capture on every IDLE issue so REQ can replay the request even if granted late.
    always_comb begin
        we_d        = we_q;
        off_d       = off_q;
        width_d     = width_q;
        addr_d      = addr_q;
        wmask_d     = wmask_q;
        wdata_d     = wdata_q;
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
        if ((state_q == IDLE) && idle_req) begin
            we_d    = req_we;
            off_d   = req_off;
            width_d = req_width;
            addr_d  = req_addr[31:2];
            wmask_d = req_wmask;
            wdata_d = req_wdata_al;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q        <= 1'b0;
            off_q       <= 2'd0;
            width_q     <= 3'd0;
            addr_q      <= 30'd0;
            wmask_q     <= 4'd0;
            wdata_q     <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            we_q        <= we_d;
            off_q       <= off_d;
            width_q     <= width_d;
            addr_q      <= addr_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ama_riscv_dmem_ctrl.sv
// Self-checking bench for ama_riscv_dmem_ctrl: scenario tasks plus a load-result scoreboard.
module tb_ama_riscv_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_width;
    logic        stall, fault, mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        lsm_en;
    logic [1:0]  lsm_offset;
    logic [2:0]  lsm_width;
    logic [31:0] lsm_data, stall_cnt;

    typedef struct packed {
        logic [1:0]  off;
        logic [2:0]  width;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    ama_riscv_dmem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_width(req_width), .req_wdata(req_wdata),
        .stall(stall), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .lsm_en(lsm_en), .lsm_offset(lsm_offset), .lsm_width(lsm_width),
        .lsm_data(lsm_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_width  = 3'd0;
        req_wdata  = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_cnt = 32'd0;
    endtask

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [2:0] width,
                             input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                             input logic [31:0] rdata, input logic [3:0] exp_mask,
                             input logic [31:0] exp_wdata);
        exp_t e;
        tick();
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_width  = width;
        req_wdata  = wdata;
        mem_gnt    = (gnt_dly == 0);
        mem_rvalid = 1'b0;
        if (!we) begin
            e.off   = addr[1:0];
            e.width = width;
            e.data  = rdata;
            sb.push_back(e);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wmask, stall, fault} !==
            {1'b1, we, addr[31:2], exp_mask, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL issue addr=%h: got req=%b we=%b maddr=%h mask=%b stall=%b fault=%b, want req=1 we=%b maddr=%h mask=%b stall=1 fault=0",
                     addr, mem_req, mem_we, mem_addr, mem_wmask, stall, fault, we, addr[31:2], exp_mask);
        end
        if (we) begin
            checks++;
            if (mem_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL issue_wdata addr=%h: got %h want %h", addr, mem_wdata, exp_wdata);
            end
        end
        for (int k = 1; k <= gnt_dly; k++) begin
            tick();
            mem_gnt = (k == gnt_dly);
            @(negedge clk);
            checks++;
            if ({mem_req, mem_addr, mem_wmask, stall} !== {1'b1, addr[31:2], exp_mask, 1'b1}) begin
                errors++;
                $display("FAIL req_hold addr=%h cyc=%0d: got req=%b maddr=%h mask=%b stall=%b, want req=1 maddr=%h mask=%b stall=1",
                         addr, k, mem_req, mem_addr, mem_wmask, stall, addr[31:2], exp_mask);
            end
        end
        for (int k = 0; k <= rv_dly; k++) begin
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = (k == rv_dly);
            mem_rdata  = (k == rv_dly) ? rdata : (32'hBAD0_0000 | k);
            @(negedge clk);
            checks++;
            if (k < rv_dly) begin
                if ({mem_req, stall, lsm_en} !== 3'b010) begin
                    errors++;
                    $display("FAIL resp_wait addr=%h cyc=%0d: got req=%b stall=%b lsm_en=%b, want 0 1 0",
                             addr, k, mem_req, stall, lsm_en);
                end
            end else begin
                if ({mem_req, stall, lsm_en} !== {1'b0, 1'b0, !we}) begin
                    errors++;
                    $display("FAIL resp_done addr=%h: got req=%b stall=%b lsm_en=%b, want 0 0 %b",
                             addr, mem_req, stall, lsm_en, !we);
                end
                if (lsm_en === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL lsm_unexpected: got lsm_en=1 with empty scoreboard, want none");
                    end else begin
                        e = sb.pop_front();
                        if ({lsm_offset, lsm_width, lsm_data} !== e) begin
                            errors++;
                            $display("FAIL lsm_data: got off=%0d width=%b data=%h, want off=%0d width=%b data=%h",
                                     lsm_offset, lsm_width, lsm_data, e.off, e.width, e.data);
                        end
                    end
                end
            end
        end
        exp_cnt = exp_cnt + 32'(1 + gnt_dly + rv_dly);
    endtask

    task automatic idle();
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({mem_req, stall, lsm_en, fault, stall_cnt} !== {4'b0000, exp_cnt}) begin
            errors++;
            $display("FAIL idle: got req=%b stall=%b lsm_en=%b fault=%b cnt=%0d, want 0 0 0 0 cnt=%0d",
                     mem_req, stall, lsm_en, fault, stall_cnt, exp_cnt);
        end
    endtask

    task automatic fault_case(input logic we, input logic [31:0] addr, input logic [2:0] width);
        tick();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_width = width;
        req_wdata = 32'h1122_3344;
        mem_gnt   = 1'b1;
        @(negedge clk);
        checks++;
        if ({fault, mem_req, stall} !== 3'b100) begin
            errors++;
            $display("FAIL fault we=%b addr=%h w=%b: got fault=%b req=%b stall=%b, want 1 0 0",
                     we, addr, width, fault, mem_req, stall);
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        #3;
        checks++;
        if ({mem_req, stall, fault, lsm_en, stall_cnt} !== {4'b0000, 32'd0}) begin
            errors++;
            $display("FAIL reset: got req=%b stall=%b fault=%b lsm_en=%b cnt=%0d, want all 0",
                     mem_req, stall, fault, lsm_en, stall_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_cnt = 32'd0;
    endtask

    task automatic test_load_word();
        do_access(1'b0, 32'h100, 3'b010, 32'd0, 0, 0, 32'hDEAD_BEEF, 4'b0000, 32'd0);
        idle();
    endtask

    task automatic test_store_byte();
        apply_reset();
        do_access(1'b1, 32'h203, 3'b000, 32'h0000_00A5, 3, 2, 32'd0, 4'b1000, 32'hA500_0000);
        idle();
        checks++;
        if (stall_cnt !== 32'd6) begin
            errors++;
            $display("FAIL store_byte_cnt: got %0d want 6", stall_cnt);
        end
    endtask

    task automatic test_store_half();
        do_access(1'b1, 32'h6, 3'b001, 32'h1234_BEEF, 1, 0, 32'd0, 4'b1100, 32'hBEEF_0000);
        do_access(1'b1, 32'h1, 3'b000, 32'h0000_005A, 0, 1, 32'd0, 4'b0010, 32'h0000_5A00);
        idle();
    endtask

    task automatic test_faults();
        fault_case(1'b0, 32'h7, 3'b001);
        fault_case(1'b1, 32'h2, 3'b010);
        fault_case(1'b1, 32'h8, 3'b100);
        fault_case(1'b0, 32'h8, 3'b011);
        fault_case(1'b1, 32'h4, 3'b101);
        // State must still be IDLE: an aligned half load issues right away.
        do_access(1'b0, 32'h2, 3'b101, 32'd0, 0, 0, 32'hCAFE_F00D, 4'b0000, 32'd0);
        idle();
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 32'h13, 3'b000, 32'd0, 0, 1, 32'h0102_0304, 4'b0000, 32'd0);
        do_access(1'b0, 32'h22, 3'b101, 32'd0, 2, 0, 32'hA0B0_C0D0, 4'b0000, 32'd0);
        do_access(1'b0, 32'h40, 3'b010, 32'd0, 0, 0, 32'h5555_AAAA, 4'b0000, 32'd0);
        idle();
    endtask

    task automatic test_reset_mid_access();
        tick();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h40;
        req_width = 3'b010;
        mem_gnt   = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({mem_req, stall} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_req: got req=%b stall=%b, want 1 1", mem_req, stall);
        end
        #2;
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req, stall, stall_cnt} !== {2'b00, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_async: got req=%b stall=%b cnt=%0d, want 0 0 0",
                     mem_req, stall, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 32'd0;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        @(negedge clk);
        checks++;
        if ({lsm_en, stall, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL stale_rvalid: got lsm_en=%b stall=%b req=%b, want 0 0 0",
                     lsm_en, stall, mem_req);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_store_half();
        test_faults();
        test_back_to_back();
        test_reset_mid_access();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending loads, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
